// File: rtl/cavlc_stage_scheduler.sv
// Sequences the five CAVLC encode stages of one block and steers the bitstream-packer mux.
// Define CAVLC_SCHED_WDOG_EN to compile in the per-stage 255-cycle watchdog.
module cavlc_stage_scheduler #(
   parameter int unsigned NZQ_WIDTH = 5,
   parameter int unsigned MAX_COEFF = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_mb,
   input  logic [NZQ_WIDTH-1:0] NZQ,
   input  logic [1:0]           T1s,
   input  logic [3:0]           total_zeros,
   input  logic [4:0]           stage_done,
   output logic [4:0]           stage_start,
   output logic [2:0]           out_sel,
   output logic                 busy,
   output logic                 mb_done,
   output logic                 err
);

   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StCt   = 3'd1;
   localparam logic [2:0] StT1   = 3'd2;
   localparam logic [2:0] StLev  = 3'd3;
   localparam logic [2:0] StTz   = 3'd4;
   localparam logic [2:0] StRb   = 3'd5;
   localparam logic [2:0] StFin  = 3'd6;

   logic [2:0]           state_q, state_d;
   logic [NZQ_WIDTH-1:0] nzq_q, nzq_d;
   logic [1:0]           t1s_q, t1s_d;
   logic [3:0]           tz_q, tz_d;
   logic [4:0]           start_q, start_d;
   logic                 err_q, err_d;

   logic       in_stage;
   logic [2:0] stage_idx;
   logic [4:0] act_mask;
   logic [4:0] skip;
   logic [2:0] next_st;
   logic       done_seen;
   logic       req_ok;

`ifdef CAVLC_SCHED_WDOG_EN
   logic [7:0] wdog_q, wdog_d;
`endif

   assign in_stage  = (state_q >= StCt) && (state_q <= StRb);
   assign stage_idx = state_q - StCt;
   assign act_mask  = in_stage ? (5'b00001 << stage_idx) : 5'b00000;
   // The start-pulse cycle never counts as completion, even if done is already high.
   assign done_seen = (start_q == 5'b00000) && |(stage_done & act_mask);
   assign req_ok    = (NZQ_WIDTH'(T1s) <= NZQ) && (32'(NZQ) <= MAX_COEFF);

   always_comb begin
      skip[0] = 1'b0;
      skip[1] = (nzq_q == '0) || (t1s_q == 2'd0);
      skip[2] = (nzq_q == '0) || (nzq_q == NZQ_WIDTH'(t1s_q));
      skip[3] = (nzq_q == '0) || (nzq_q == NZQ_WIDTH'(MAX_COEFF));
      skip[4] = (nzq_q < NZQ_WIDTH'(2)) || (tz_q == 4'd0);
   end

   // Lowest-indexed enabled stage after the current one; FIN if none remain.
   always_comb begin
      next_st = StFin;
      for (int s = 4; s >= 0; s--) begin
         if (s > int'(stage_idx) && !skip[s]) next_st = 3'(s + 1);
      end
   end

   always_comb begin
      state_d = state_q;
      nzq_d   = nzq_q;
      t1s_d   = t1s_q;
      tz_d    = tz_q;
      start_d = 5'b00000;
      err_d   = 1'b0;
      case (state_q)
         StIdle: begin
            if (start_mb) begin
               if (req_ok) begin
                  nzq_d   = NZQ;
                  t1s_d   = T1s;
                  tz_d    = total_zeros;
                  state_d = StCt;
                  start_d = 5'b00001;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StCt, StT1, StLev, StTz, StRb: begin
            if (done_seen) begin
               state_d = next_st;
               if (next_st != StFin) start_d = 5'b00001 << (next_st - StCt);
            end
`ifdef CAVLC_SCHED_WDOG_EN
            else if (wdog_q == 8'd254) begin
               state_d = StIdle;
               err_d   = 1'b1;
            end
`endif
         end
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

`ifdef CAVLC_SCHED_WDOG_EN
   assign wdog_d = (start_d != 5'b00000) ? 8'd0 : (in_stage ? wdog_q + 8'd1 : 8'd0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) wdog_q <= 8'd0;
      else      wdog_q <= wdog_d;
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         nzq_q   <= '0;
         t1s_q   <= 2'd0;
         tz_q    <= 4'd0;
         start_q <= 5'b00000;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         nzq_q   <= nzq_d;
         t1s_q   <= t1s_d;
         tz_q    <= tz_d;
         start_q <= start_d;
         err_q   <= err_d;
      end
   end

   assign stage_start = start_q;
   assign out_sel     = in_stage ? stage_idx : 3'd7;
   assign busy        = (state_q != StIdle);
   assign mb_done     = (state_q == StFin);
   assign err         = err_q;

endmodule

// File: tb/tb_cavlc_stage_scheduler.sv
// Self-checking bench for cavlc_stage_scheduler: directed and random blocks against a stage-plan model.
// Watchdog scenario is selected by CAVLC_SCHED_WDOG_EN, matching the RTL build.
module tb_cavlc_stage_scheduler;

   localparam int MC = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_mb = 1'b0;
   logic [4:0] nzq = '0;
   logic [1:0] t1s = '0;
   logic [3:0] tz = '0;
   logic [4:0] stage_done = '0;
   logic [4:0] stage_start;
   logic [2:0] out_sel;
   logic       busy, mb_done, err;

   int n_cmp = 0;
   int n_bad = 0;
   int plan[$];

   cavlc_stage_scheduler #(.NZQ_WIDTH(5), .MAX_COEFF(MC)) dut (
      .clk(clk), .rst(rst), .start_mb(start_mb), .NZQ(nzq), .T1s(t1s),
      .total_zeros(tz), .stage_done(stage_done), .stage_start(stage_start),
      .out_sel(out_sel), .busy(busy), .mb_done(mb_done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Stages a block visits, straight from the skip rules.
   function automatic void make_plan(input int n, input int t, input int z);
      plan.delete();
      plan.push_back(0);
      if (n != 0) begin
         if (t != 0) plan.push_back(1);
         if (n != t) plan.push_back(2);
         if (n != MC) plan.push_back(3);
         if (n >= 2 && z != 0) plan.push_back(4);
      end
   endfunction

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_start"}, stage_start, 0);
      chk({tag, "_sel"}, out_sel, 7);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_mbd"}, mb_done, 0);
      chk({tag, "_err"}, err, 0);
   endtask

   // Called at a negedge with the DUT idle; returns the FIN cycle index (start cycle = 0) or -1.
   task automatic run_block(input int n, input int t, input int z, input int max_lat,
                            input bit noise, output int mb_cycle);
      bit         bad;
      int         cyc;
      int         lat;
      int         s;
      logic [4:0] d;
      bad = (t > n) || (n > MC);
      cyc = 0;
      chk("idle_busy", busy, 0);
      nzq = 5'(n); t1s = 2'(t); tz = 4'(z);
      start_mb = 1'b1;
      stage_done = noise ? 5'($urandom) : 5'b0;
      if (bad) begin
         @(negedge clk);
         start_mb = 1'b0;
         chk("inv_err", err, 1);
         chk("inv_busy", busy, 0);
         chk("inv_start", stage_start, 0);
         chk("inv_sel", out_sel, 7);
         @(negedge clk);
         chk("inv_err_end", err, 0);
         chk("inv_busy2", busy, 0);
         mb_cycle = -1;
         return;
      end
      make_plan(n, t, z);
      foreach (plan[i]) begin
         s = plan[i];
         lat = int'($urandom_range(max_lat, 1));
         for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            cyc++;
            chk("stg_start", stage_start, (k == 0) ? (1 << s) : 0);
            chk("stg_sel", out_sel, s);
            chk("stg_busy", busy, 1);
            chk("stg_mbd", mb_done, 0);
            chk("stg_err", err, 0);
            start_mb = noise ? 1'($urandom) : 1'b0;
            if (noise) begin
               nzq = 5'($urandom); t1s = 2'($urandom); tz = 4'($urandom);
            end
            d = noise ? 5'($urandom) : 5'b0;
            d[s] = (k == lat) ? 1'b1 : ((k == 0 && noise) ? 1'($urandom) : 1'b0);
            stage_done = d;
         end
      end
      @(negedge clk);
      cyc++;
      chk("fin_mbd", mb_done, 1);
      chk("fin_sel", out_sel, 7);
      chk("fin_busy", busy, 1);
      chk("fin_start", stage_start, 0);
      chk("fin_err", err, 0);
      mb_cycle = cyc;
      start_mb = noise ? 1'($urandom) : 1'b0;
      stage_done = 5'b0;
      @(negedge clk);
      start_mb = 1'b0;
      chk("post_busy", busy, 0);
      chk("post_mbd", mb_done, 0);
      chk("post_sel", out_sel, 7);
      chk("post_start", stage_start, 0);
   endtask

   // Drives single-cycle dones until the LEV start pulse is seen; leaves the bench at that negedge.
   task automatic reach_lev(input bit hold_start, output bit found);
      found = 1'b0;
      nzq = 5'd5; t1s = 2'd2; tz = 4'd3;
      start_mb = 1'b1;
      stage_done = 5'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         start_mb = hold_start;
         if (stage_start == 5'b00100) begin
            found = 1'b1;
            stage_done = 5'b0;
         end else if (stage_start == 5'b0 && out_sel < 3'd5) begin
            stage_done = 5'b00001 << out_sel;
         end else begin
            stage_done = 5'b0;
         end
      end
   endtask

   initial begin
      int  mbc;
      int  n, t, z;
      bit  found;
      bit  seen_mb;

      #1 rst = 1'b0;
      #2 chk_reset_outs("rst0");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      run_block(5, 2, 3, 1, 1'b0, mbc);
      chk("all5_latency", 32'(mbc), 11);
      run_block(0, 0, 0, 1, 1'b0, mbc);
      chk("nzq0_latency", 32'(mbc), 3);
      run_block(16, 3, 0, 1, 1'b0, mbc);
      chk("nzq16_latency", 32'(mbc), 7);
      run_block(1, 2, 0, 1, 1'b0, mbc);
      chk("inv_t1s_ret", 32'(mbc), 32'hffff_ffff);
      run_block(17, 0, 4, 1, 1'b0, mbc);
      chk("inv_nzq_ret", 32'(mbc), 32'hffff_ffff);
      run_block(1, 1, 0, 2, 1'b1, mbc);
      run_block(16, 0, 5, 3, 1'b1, mbc);

      for (int b = 0; b < 40; b++) begin
         n = ($urandom_range(9, 0) == 0) ? int'($urandom_range(31, 17)) : int'($urandom_range(16, 0));
         t = int'($urandom_range(3, 0));
         z = ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(15, 0));
         run_block(n, t, z, 3, 1'b1, mbc);
      end

      // Reset asserted mid-LEV with start_mb held high.
      reach_lev(1'b1, found);
      chk("rst_lev_found", 32'(found), 1);
      #2 rst = 1'b0;
      #1 chk_reset_outs("rst_mid");
      @(posedge clk);
      #1 chk_reset_outs("rst_hold");
      @(negedge clk);
      rst = 1'b1;
      chk("rst_rel_busy", busy, 0);
      @(negedge clk);
      chk("rst_acc_start", stage_start, 1);
      chk("rst_acc_sel", out_sel, 0);
      chk("rst_acc_busy", busy, 1);
      start_mb = 1'b0;
      rst = 1'b0;
      #1 chk("rst_clean_busy", busy, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      reach_lev(1'b0, found);
      chk("wd_lev_found", 32'(found), 1);
`ifdef CAVLC_SCHED_WDOG_EN
      seen_mb = 1'b0;
      for (int k = 1; k <= 256; k++) begin
         @(negedge clk);
         if (mb_done) seen_mb = 1'b1;
         if (k < 255) begin
            chk("wd_wait_err", err, 0);
            chk("wd_wait_sel", out_sel, 2);
         end else if (k == 255) begin
            chk("wd_err", err, 1);
            chk("wd_busy", busy, 0);
            chk("wd_sel", out_sel, 7);
            chk("wd_start", stage_start, 0);
         end else begin
            chk("wd_err_end", err, 0);
            chk("wd_idle", busy, 0);
         end
      end
      chk("wd_no_mbd", 32'(seen_mb), 0);
`else
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         chk("nowd_err", err, 0);
         if (k == 300) begin
            chk("nowd_busy", busy, 1);
            chk("nowd_sel", out_sel, 2);
         end
      end
      stage_done = 5'b00100;
      seen_mb = 1'b0;
      for (int c = 0; c < 20 && !seen_mb; c++) begin
         @(negedge clk);
         if (mb_done) seen_mb = 1'b1;
         stage_done = (stage_start == 5'b0 && out_sel < 3'd5) ? (5'b00001 << out_sel) : 5'b0;
      end
      chk("nowd_finish", 32'(seen_mb), 1);
      stage_done = 5'b0;
      @(negedge clk);
      chk("nowd_idle", busy, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cavlc_stage_scheduler.md
CAVLC_STAGE_SCHEDULER -- requirements
Module: cavlc_stage_scheduler

Interface
REQ-001 SHALL have parameter NZQ_WIDTH, default 5, meaning the width of the nonzero-coefficient count.
REQ-002 SHALL have parameter MAX_COEFF, default 16, meaning the maximum number of coefficients in a block (4 for chroma DC).
REQ-003 SHALL have port clk, input, 1 bit, meaning the clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1 bit, meaning reset, asynchronous, active-low.
REQ-005 SHALL have port start_mb, input, 1 bit, meaning a request to encode one block.
REQ-006 SHALL have port NZQ, input, NZQ_WIDTH bits, meaning the total nonzero coefficients.
REQ-007 SHALL have port T1s, input, 2 bits, meaning the trailing ones count.
REQ-008 SHALL have port total_zeros, input, 4 bits, meaning the zeros before the last nonzero coefficient.
REQ-009 SHALL have port stage_done, input, 5 bits, meaning per-stage completion: bit0 coeff_token, bit1 t1_sign, bit2 levels, bit3 total_zeros, bit4 run_before.
REQ-010 SHALL have port stage_start, output, 5 bits, meaning one-cycle start pulses with the same bit mapping as stage_done.
REQ-011 SHALL have port out_sel, output, 3 bits, meaning the bitstream-packer mux select (0..4 = active stage, 7 = none).
REQ-012 SHALL have port busy, output, 1 bit, meaning high from start acceptance until return to IDLE.
REQ-013 SHALL have port mb_done, output, 1 bit, meaning a one-cycle block-complete pulse.
REQ-014 SHALL have port err, output, 1 bit, meaning a one-cycle error pulse.

Function
REQ-015 SHALL implement states IDLE, CT, T1, LEV, TZ, RB, FIN, all registered.
REQ-016 SHALL, in IDLE with start_mb=1, latch NZQ, T1s and total_zeros, and set busy=1.
- Valid request: next state is CT.
- T1s>NZQ or NZQ>MAX_COEFF: pulse err for one cycle, stay IDLE, busy=0.
REQ-017 SHALL, on entry to each stage state, pulse the matching stage_start bit for exactly the first cycle and hold out_sel at the stage index for the whole state.
REQ-018 SHALL ignore stage_done during the start-pulse cycle and ignore stage_done bits of non-active stages.
REQ-019 SHALL advance, on the cycle after the active stage_done is sampled, to the next non-skipped stage, with its start pulse in that cycle (no idle gap).
REQ-020 SHALL apply these skip rules, evaluated on latched values:
- NZQ=0: only CT, then FIN.
- T1: skipped if T1s=0.
- LEV: skipped if NZQ=T1s.
- TZ: skipped if NZQ=MAX_COEFF.
- RB: skipped if NZQ<2 or total_zeros=0.
REQ-021 SHALL, in FIN, pulse mb_done for one cycle with out_sel=7, then enter IDLE; busy drops on IDLE entry.
REQ-022 SHALL ignore start_mb while busy=1, including in the FIN cycle; start is accepted only in IDLE.
REQ-023 SHALL make stage order fixed: CT, T1, LEV, TZ, RB.
REQ-024 SHALL, for a block running all five stages with single-cycle stage latency, take 2 cycles per stage plus 1 (start acceptance) plus 1 (FIN) = 12 cycles from start_mb to mb_done inclusive.

Reset
REQ-025 SHALL, on rst=0 at any time including mid-block, immediately force state IDLE, stage_start=0, out_sel=7, busy=0, mb_done=0, err=0, clear the latched inputs, and clear the watchdog counter.
REQ-026 SHALL, after reset release, accept start_mb no earlier than the first rising edge.

Configuration
REQ-027 SHALL use macro CAVLC_SCHED_WDOG_EN to compile in or out the per-stage watchdog.
- Defined: an 8-bit counter clears on each stage entry and increments every cycle in a stage state. On reaching 255 without the active stage_done, the block pulses err, forces IDLE and sets out_sel=7; mb_done is not asserted.
- Undefined: no counter, and the block waits indefinitely for stage_done.

Verification
REQ-028 SHALL cover: NZQ=5, T1s=2, total_zeros=3, single-cycle done -> start pulses on bits 0,1,2,3,4 in order, mb_done 12 cycles after start_mb.
REQ-029 SHALL cover: NZQ=0 -> only stage_start[0], mb_done 4 cycles after start_mb, out_sel 0 then 7.
REQ-030 SHALL cover: NZQ=16, T1s=3, total_zeros=0 -> CT, T1, LEV only; TZ and RB never started.
REQ-031 SHALL cover: NZQ=1, T1s=2 -> err pulse, no stage_start, busy stays 0.
REQ-032 SHALL cover: rst asserted during LEV with start_mb held high -> all outputs at reset values immediately; new block accepted only after release.
REQ-033 SHALL cover, with CAVLC_SCHED_WDOG_EN defined: stage_done[2] withheld -> err pulse 255 cycles after LEV entry, return to IDLE, no mb_done.
